// File: rtl/vmicro16_apb_ex_master_pkg.sv
// rtl/vmicro16_apb_ex_master_pkg.sv - PADDR field layout, SWEX result codes and bridge FSM encoding
// Shared with the exclusive BRAM so both ends decode PADDR identically.
package vmicro16_apb_ex_master_pkg;

  localparam logic [15:0] APB_SWEX_SUCCESS = 16'h0000;
  localparam logic [15:0] APB_SWEX_FAIL    = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  function automatic int lwex_bit(input int apb_width);
    return apb_width - 1;
  endfunction

  function automatic int swex_bit(input int apb_width);
    return apb_width - 2;
  endfunction

  function automatic int core_id_msb(input int apb_width);
    return apb_width - 3;
  endfunction

endpackage

// File: rtl/vmicro16_apb_watchdog.sv
// rtl/vmicro16_apb_watchdog.sv - loadable down-counter that flags the cycle consuming its last tick
module vmicro16_apb_watchdog #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Expiry is combinational so the owner can leave on the same cycle the limit is hit.
  assign expired = en && !clear && !load && (count_q == WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vmicro16_apb_ex_master.sv
// rtl/vmicro16_apb_ex_master.sv - per-core APB master bridge carrying LWEX/SWEX flags and core ID in PADDR
module vmicro16_apb_ex_master
  import vmicro16_apb_ex_master_pkg::*;
#(
  parameter int                    APB_WIDTH      = 20,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    CORE_ID        = 0,
  parameter int                    CORE_ID_BITS   = 2,
  parameter logic [DATA_WIDTH-1:0] SWEX_SUCCESS   = DATA_WIDTH'(APB_SWEX_SUCCESS),
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_lwex,
  input  logic                  req_swex,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_swex_ok,
  output logic                  resp_err,
  output logic [APB_WIDTH-1:0]  w_PADDR,
  output logic                  w_PWRITE,
  output logic                  w_PSELx,
  output logic                  w_PENABLE,
  output logic [DATA_WIDTH-1:0] w_PWDATA,
  input  logic [DATA_WIDTH-1:0] w_PRDATA,
  input  logic                  w_PREADY
);

  localparam int LWEX_BIT = lwex_bit(APB_WIDTH);
  localparam int SWEX_BIT = swex_bit(APB_WIDTH);
  localparam int CID_MSB  = core_id_msb(APB_WIDTH);
  localparam int WD_WIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CORE_ID_BITS-1:0] CORE_ID_F = CORE_ID_BITS'(CORE_ID);

  apb_state_e state_q, state_d;
  logic [APB_WIDTH-1:0]  paddr_q, paddr_d, req_paddr;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  swex_ok_q, swex_ok_d;
  logic                  err_q, err_d;
  logic                  wd_expired;
  logic                  timeout;

  vmicro16_apb_watchdog #(.WIDTH(WD_WIDTH)) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      ((state_q == ST_IDLE) || (state_q == ST_DONE)),
    .load       (state_q == ST_SETUP),
    .load_value (WD_WIDTH'(TIMEOUT_CYCLES)),
    .en         (WD_EN && (state_q == ST_ACCESS) && !w_PREADY),
    .expired    (wd_expired)
  );

  assign timeout = WD_EN && wd_expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      swex_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      swex_ok_q <= swex_ok_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = (req_lwex && req_swex) ? ST_DONE : ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (w_PREADY || timeout) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_paddr                             = '0;
    req_paddr[ADDR_WIDTH-1:0]             = req_addr;
    req_paddr[CID_MSB -: CORE_ID_BITS]    = CORE_ID_F;
    req_paddr[LWEX_BIT]                   = req_lwex;
    req_paddr[SWEX_BIT]                   = req_swex;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    swex_ok_d = swex_ok_q;
    err_d     = err_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      if (req_lwex && req_swex) begin
        rdata_d   = '0;
        swex_ok_d = 1'b0;
        err_d     = 1'b1;
      end else begin
        paddr_d  = req_paddr;
        pwrite_d = req_write | req_swex;
        pwdata_d = req_wdata;
      end
    end
    // PREADY wins over a watchdog hit on the same cycle.
    if (state_q == ST_ACCESS) begin
      if (w_PREADY) begin
        rdata_d   = w_PRDATA;
        swex_ok_d = paddr_q[SWEX_BIT] && (w_PRDATA == SWEX_SUCCESS);
        err_d     = 1'b0;
      end else if (timeout) begin
        rdata_d   = '0;
        swex_ok_d = 1'b0;
        err_d     = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    w_PSELx    = 1'b0;
    w_PENABLE  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE:   req_ready = 1'b1;
      ST_SETUP:  w_PSELx = 1'b1;
      ST_ACCESS: begin
        w_PSELx   = 1'b1;
        w_PENABLE = 1'b1;
      end
      default:   resp_valid = 1'b1;
    endcase
  end

  assign w_PADDR      = paddr_q;
  assign w_PWRITE     = pwrite_q;
  assign w_PWDATA     = pwdata_q;
  assign resp_rdata   = rdata_q;
  assign resp_swex_ok = swex_ok_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_vmicro16_apb_ex_master.sv
// tb/tb_vmicro16_apb_ex_master.sv - randomized bench for the APB master bridge against a transaction-level model
module tb_vmicro16_apb_ex_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_lwex = 1'b0, req_swex = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        pready = 1'b0;
  logic [15:0] prdata = '0;

  logic        a_req_ready, a_resp_valid, a_ok, a_err, a_pwrite, a_psel, a_penable;
  logic [15:0] a_rdata, a_pwdata;
  logic [19:0] a_paddr;
  logic        t_req_ready, t_resp_valid, t_ok, t_err, t_pwrite, t_psel, t_penable;
  logic [15:0] t_rdata, t_pwdata;
  logic [19:0] t_paddr;

  logic        m_req_ready, m_resp_valid, m_ok, m_err, m_pwrite, m_psel, m_penable;
  logic [15:0] m_rdata, m_pwdata;
  logic [19:0] m_paddr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] hold_rdata[2];
  logic        hold_ok[2];
  logic        hold_err[2];

  always #5 clk = ~clk;

  vmicro16_apb_ex_master #(.CORE_ID(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_lwex(req_lwex), .req_swex(req_swex), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_rdata), .resp_swex_ok(a_ok),
    .resp_err(a_err), .w_PADDR(a_paddr), .w_PWRITE(a_pwrite), .w_PSELx(a_psel),
    .w_PENABLE(a_penable), .w_PWDATA(a_pwdata), .w_PRDATA(prdata), .w_PREADY(pready & ~sel)
  );

  vmicro16_apb_ex_master #(.CORE_ID(1), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(t_req_ready),
    .req_write(req_write), .req_lwex(req_lwex), .req_swex(req_swex), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(t_resp_valid), .resp_rdata(t_rdata), .resp_swex_ok(t_ok),
    .resp_err(t_err), .w_PADDR(t_paddr), .w_PWRITE(t_pwrite), .w_PSELx(t_psel),
    .w_PENABLE(t_penable), .w_PWDATA(t_pwdata), .w_PRDATA(prdata), .w_PREADY(pready & sel)
  );

  assign m_req_ready  = sel ? t_req_ready  : a_req_ready;
  assign m_resp_valid = sel ? t_resp_valid : a_resp_valid;
  assign m_ok         = sel ? t_ok         : a_ok;
  assign m_err        = sel ? t_err        : a_err;
  assign m_pwrite     = sel ? t_pwrite     : a_pwrite;
  assign m_psel       = sel ? t_psel       : a_psel;
  assign m_penable    = sel ? t_penable    : a_penable;
  assign m_rdata      = sel ? t_rdata      : a_rdata;
  assign m_pwdata     = sel ? t_pwdata     : a_pwdata;
  assign m_paddr      = sel ? t_paddr      : a_paddr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One core request against a reactive slave; expectations come from the transaction rules.
  task automatic run_txn(input logic wr, input logic lw, input logic sw, input logic [15:0] addr,
                         input logic [15:0] wdata, input int waits, input logic [15:0] rd);
    int          s = sel ? 1 : 0;
    int          core_id = sel ? 1 : 2;
    int          tmo = sel ? 4 : 255;
    logic [19:0] e_paddr;
    logic        e_pwrite = wr | sw;
    int          e_lat, e_psel;
    logic [15:0] e_rdata;
    logic        e_ok, e_err;
    int          resp_cyc = -1, psel_n = 0, first_psel = -1, first_pen = -1, bad = 0, acc = 0;

    e_paddr = (20'(lw) << 19) | (20'(sw) << 18) | (20'(core_id) << 16) | 20'(addr);
    if (lw && sw) begin
      e_lat = 1; e_psel = 0; e_rdata = 16'h0; e_ok = 1'b0; e_err = 1'b1;
    end else if (waits >= tmo) begin
      e_lat = 2 + tmo; e_psel = 1 + tmo; e_rdata = 16'h0; e_ok = 1'b0; e_err = 1'b1;
    end else begin
      e_lat = 3 + waits; e_psel = 2 + waits; e_rdata = rd; e_ok = sw && (rd == 16'h0000); e_err = 1'b0;
    end

    @(negedge clk);
    check("idle_ready", m_req_ready, 1);
    check("idle_no_resp", m_resp_valid, 0);
    check("hold_rdata", m_rdata, hold_rdata[s]);
    check("hold_flags", {m_ok, m_err}, {hold_ok[s], hold_err[s]});
    req_valid = 1'b1; req_write = wr; req_lwex = lw; req_swex = sw;
    req_addr = addr; req_wdata = wdata; pready = 1'b0; prdata = rd;

    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      req_valid = m_req_ready ? 1'b0 : 1'($urandom_range(0, 1));
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
      req_write = 1'($urandom); req_lwex = 1'($urandom); req_swex = 1'($urandom);
      if (m_psel) begin
        psel_n++;
        if (first_psel < 0) first_psel = c;
        if (m_paddr !== e_paddr || m_pwrite !== e_pwrite || m_pwdata !== wdata) bad++;
      end
      if (m_penable) begin
        if (first_pen < 0) first_pen = c;
        acc++;
        pready = (acc > waits);
      end else begin
        pready = 1'b0;
      end
      if (m_resp_valid) begin
        resp_cyc = c;
        break;
      end
    end
    req_valid = 1'b0;

    check("resp_latency", resp_cyc, e_lat);
    check("psel_cycles", psel_n, e_psel);
    check("addr_ctrl_stable", bad, 0);
    check("first_psel", first_psel, (e_psel > 0) ? 1 : -1);
    check("first_penable", first_pen, (e_psel > 0) ? 2 : -1);
    check("resp_rdata", m_rdata, e_rdata);
    check("resp_swex_ok", m_ok, e_ok);
    check("resp_err", m_err, e_err);
    hold_rdata[s] = e_rdata; hold_ok[s] = e_ok; hold_err[s] = e_err;
  endtask

  initial begin
    int          r, resp_seen;
    logic [15:0] rd;
    for (int i = 0; i < 2; i++) begin
      hold_rdata[i] = '0; hold_ok[i] = 1'b0; hold_err[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("rst_ready", {a_req_ready, t_req_ready}, 2'b11);
    check("rst_bus", {a_psel, a_penable, a_pwrite, a_resp_valid, a_err, a_ok}, 0);
    check("rst_paddr", a_paddr, 0);
    reset = 1'b1;

    sel = 1'b0;
    run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF);
    run_txn(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 0, 16'h5678);
    run_txn(1'b0, 1'b0, 1'b1, 16'h0004, 16'h1234, 0, 16'h0000);
    run_txn(1'b0, 1'b0, 1'b1, 16'h0004, 16'h1234, 0, 16'h0001);
    run_txn(1'b1, 1'b0, 1'b0, 16'h0020, 16'hCAFE, 5, 16'h0000);
    run_txn(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555, 0, 16'h7777);

    sel = 1'b1;
    run_txn(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 50, 16'h1111);
    run_txn(1'b0, 1'b0, 1'b1, 16'h0044, 16'h2222, 3, 16'h0000);
    run_txn(1'b1, 1'b1, 1'b0, 16'h0048, 16'h3333, 4, 16'h4444);

    for (int n = 0; n < 50; n++) begin
      sel = (n >= 30);
      r = $urandom_range(0, 7);
      rd = 16'($urandom);
      if (r == 1 && $urandom_range(0, 1) == 1) rd = 16'h0000;
      run_txn(1'($urandom), (r == 0) || (r == 2), (r == 1) || (r == 2), 16'($urandom),
              16'($urandom), $urandom_range(0, 6), rd);
    end

    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_lwex = 1'b1; req_swex = 1'b0;
    req_addr = 16'h0ABC; pready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_access", {a_psel, a_penable}, 2'b11);
    #2 reset = 1'b0;
    #1;
    check("async_rst_bus", {a_psel, a_penable, a_pwrite, a_resp_valid}, 0);
    check("async_rst_paddr", a_paddr, 0);
    check("async_rst_ready", a_req_ready, 1);
    resp_seen = 0;
    repeat (2) begin
      @(negedge clk);
      resp_seen += int'(a_resp_valid);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      resp_seen += int'(a_resp_valid) + int'(a_psel);
    end
    check("no_resp_after_reset", resp_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vmicro16_apb_ex_master.md
Name: vmicro16_apb_ex_master

Overview:
- Per-core APB master bridge. Sits between a vmicro16 core's load/store path and one master port of the shared APB interconnect, upstream of the exclusive-access BRAM.
- Turns core requests (plain LW/SW, LWEX, SWEX) into APB transfers. Encodes the LWEX/SWEX flags and CORE_ID into the upper PADDR bits.
- Returns read data and the SWEX success flag to the core. A watchdog aborts stalled transfers.

Parameters:
- APB_WIDTH, 20, PADDR width; bit APB_WIDTH-1 = LWEX, bit APB_WIDTH-2 = SWEX.
- DATA_WIDTH, 16, PWDATA/PRDATA width.
- ADDR_WIDTH, 16, core address width; occupies PADDR[ADDR_WIDTH-1:0].
- CORE_ID, 0, this core's ID.
- CORE_ID_BITS, 2, ID field width; occupies PADDR[APB_WIDTH-3 -: CORE_ID_BITS].
- SWEX_SUCCESS, 16'h0000, PRDATA value the slave returns on a successful SWEX.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write.
- req_lwex  in  1  exclusive load.
- req_swex  in  1  exclusive store.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  read data; raw PRDATA for SWEX.
- resp_swex_ok  out  1  SWEX succeeded.
- resp_err  out  1  timeout or illegal request.
- w_PADDR  out  APB_WIDTH  APB address.
- w_PWRITE  out  1  APB write.
- w_PSELx  out  1  APB select.
- w_PENABLE  out  1  APB enable.
- w_PWDATA  out  DATA_WIDTH  APB write data.
- w_PRDATA  in  DATA_WIDTH  APB read data.
- w_PREADY  in  1  APB ready.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, timeout counter 0. All outputs 0 except req_ready, which is 1.
- States: IDLE, SETUP, ACCESS, DONE.
- req_ready = (state == IDLE).
- IDLE:
  - req_valid high: latch PADDR = {lwex, swex, CORE_ID, zero pad, addr}, PWRITE = req_write | req_swex, PWDATA = req_wdata. Go to SETUP.
  - req_lwex & req_swex both set: illegal. Do not start a bus transfer; go to DONE with err = 1, rdata = 0.
- SETUP: PSELx = 1, PENABLE = 0. Exactly one cycle, then ACCESS.
- ACCESS:
  - PSELx = 1, PENABLE = 1. Counter increments each cycle PREADY is low.
  - PREADY high: capture PRDATA into resp_rdata. swex_ok = latched_swex & (PRDATA == SWEX_SUCCESS). Go to DONE.
  - TIMEOUT_CYCLES ≠ 0 and counter reaches TIMEOUT_CYCLES with PREADY low: go to DONE with err = 1, rdata = 0, swex_ok = 0.
- DONE: resp_valid = 1 for exactly one cycle, PSELx = PENABLE = 0, then IDLE.
- resp_rdata, resp_swex_ok and resp_err hold their value until the next DONE.
- Latency with zero-wait slave: accept at cycle 0, SETUP at 1, ACCESS at 2, DONE/resp_valid at 3. Each PREADY wait cycle adds one.
- PADDR, PWRITE and PWDATA are stable from SETUP through ACCESS. They change only in IDLE.
- A new req_valid is ignored outside IDLE. The core must hold the request until req_ready.
- LWEX is a read (PWRITE = 0). SWEX is a write. resp_swex_ok is always 0 for non-SWEX transfers.
- A PREADY high in the same cycle the counter hits the limit counts as success; PREADY takes priority.
- If reset is asserted mid-transfer, the transfer is abandoned: no resp_valid, and the bus is released immediately.

Decomposition:
- Shared package/include holds:
  - PADDR field positions (LWEX_BIT, SWEX_BIT, CORE_ID_MSB) from APB_WIDTH.
  - SWEX_SUCCESS / SWEX_FAIL constants.
  - State encoding.
- These are shared with the exclusive BRAM so encodings cannot drift.
- One natural sub-module: vmicro16_apb_watchdog, a loadable down-counter with enable, clear and expiry flag.

Test Plan:
- Plain read: addr 16'h0010, slave returns 16'hBEEF with zero wait. PSELx high cycles 1–2, PENABLE cycle 2, resp_valid cycle 3, rdata 16'hBEEF, swex_ok 0, err 0.
- LWEX then SWEX from CORE_ID = 2 to addr 16'h0004, wdata 16'h1234:
  - LWEX PADDR = 20'h A0004, PWRITE 0.
  - SWEX PADDR = 20'h 60004, PWRITE 1.
  - Slave returns 16'h0000 → resp_swex_ok 1.
- SWEX fail: slave returns 16'h0001 → resp_swex_ok 0, resp_rdata 16'h0001, err 0.
- Wait states: PREADY held low 5 cycles. resp_valid at cycle 8. PADDR/PWDATA unchanged throughout ACCESS.
- Timeout: TIMEOUT_CYCLES = 4, PREADY never high. Abort after 4 ACCESS cycles; resp_valid with err 1, rdata 0. Next request accepted the following cycle.
- Illegal and reset cases:
  - req_lwex = req_swex = 1: no PSELx ever asserted; resp_valid one cycle later with err 1.
  - reset pulled low during ACCESS: all APB outputs 0 asynchronously, no resp_valid.
